// File: rtl/dpll_lock_ctrl_if.sv
// Bus between the DPLL lock controller and its environment: enable, reference/DCO
// strobes and target count in; DCO code, lock and phase-event pulses out.
interface dpll_lock_ctrl_if #(
    parameter int unsigned CNT_W = 12
);
    logic             i_en;
    logic             i_ref_edge;
    logic             i_dco_tick;
    logic [CNT_W-1:0] i_tgt_cnt;
    logic [7:0]       o_code;
    logic             o_lock;
    logic             o_p_up;
    logic             o_p_down;
    logic             o_sar_done;

    modport master (
        output i_en, i_ref_edge, i_dco_tick, i_tgt_cnt,
        input  o_code, o_lock, o_p_up, o_p_down, o_sar_done
    );

    modport slave (
        input  i_en, i_ref_edge, i_dco_tick, i_tgt_cnt,
        output o_code, o_lock, o_p_up, o_p_down, o_sar_done
    );
endinterface

// File: rtl/dpll_lock_ctrl.sv
// DPLL lock controller: 8-bit SAR search of the DCO code against a per-window edge count,
// then active-low p_up/p_down phase events while locked, restarting on persistent loss.
module dpll_lock_ctrl #(
    parameter int unsigned REF_WIN  = 4,
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned PULSE_W  = 2,
    parameter int unsigned LOCK_TOL = 2,
    parameter int unsigned LOSS_N   = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    dpll_lock_ctrl_if.slave io_bus
);
    localparam int unsigned RW_W = (REF_WIN > 1) ? $clog2(REF_WIN) : 1;
    localparam int unsigned PC_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam int unsigned LS_W = $clog2(LOSS_N + 1);
    localparam int unsigned DW   = CNT_W + 1;
    localparam logic signed [DW-1:0] TOL_P = DW'(LOCK_TOL);
    localparam logic signed [DW-1:0] TOL_N = -TOL_P;

    typedef enum logic [1:0] {IDLE, SETTLE, MEAS, TRACK} state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_bit, w_bit_nxt, w_bit_m1;
    logic [7:0]       r_code, w_code_nxt, w_trial;
    logic             r_lock, w_lock_nxt;
    logic             r_p_up, w_p_up_nxt;
    logic             r_p_down, w_p_down_nxt;
    logic             r_sar_done, w_sar_done_nxt;
    logic [PC_W-1:0]  r_pcnt, w_pcnt_nxt;
    logic [LS_W-1:0]  r_loss, w_loss_nxt, w_loss_inc;

    logic             r_open;
    logic [RW_W-1:0]  r_ref_cnt;
    logic [CNT_W-1:0] r_dco_cnt, r_res_cnt, w_cnt_inc;
    logic             r_res_valid;
    logic             w_meas_clr, w_close;
    logic signed [DW-1:0] w_diff;
    logic             w_gt, w_lt, w_out_tol, w_pulse_act;

    // Window measurement: the closing ref_edge of one window opens the next
    assign w_meas_clr = (r_state == IDLE) || !io_bus.i_en;
    assign w_cnt_inc  = (io_bus.i_dco_tick && (r_dco_cnt != {CNT_W{1'b1}}))
                        ? r_dco_cnt + CNT_W'(1) : r_dco_cnt;
    assign w_close    = r_open && io_bus.i_ref_edge && (r_ref_cnt == RW_W'(REF_WIN - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst || w_meas_clr) begin
            r_open      <= 1'b0;
            r_ref_cnt   <= '0;
            r_dco_cnt   <= '0;
            r_res_valid <= 1'b0;
            r_res_cnt   <= '0;
        end else begin
            r_res_valid <= w_close;
            if (w_close) r_res_cnt <= w_cnt_inc;
            if (io_bus.i_ref_edge) begin
                r_open    <= 1'b1;
                r_ref_cnt <= (w_close || !r_open) ? '0 : r_ref_cnt + RW_W'(1);
                r_dco_cnt <= (w_close || !r_open) ? '0 : w_cnt_inc;
            end else if (r_open) begin
                r_dco_cnt <= w_cnt_inc;
            end
        end
    end

    assign w_diff      = $signed({1'b0, r_res_cnt}) - $signed({1'b0, io_bus.i_tgt_cnt});
    assign w_lt        = w_diff[DW-1];
    assign w_gt        = !w_diff[DW-1] && (w_diff != '0);
    assign w_out_tol   = (w_diff > TOL_P) || (w_diff < TOL_N);
    assign w_pulse_act = !r_p_up || !r_p_down;
    assign w_loss_inc  = r_loss + LS_W'(1);
    assign w_bit_m1    = r_bit - 3'd1;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_bit      <= 3'd7;
            r_code     <= 8'h00;
            r_lock     <= 1'b0;
            r_p_up     <= 1'b1;
            r_p_down   <= 1'b1;
            r_sar_done <= 1'b0;
            r_pcnt     <= '0;
            r_loss     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit      <= w_bit_nxt;
            r_code     <= w_code_nxt;
            r_lock     <= w_lock_nxt;
            r_p_up     <= w_p_up_nxt;
            r_p_down   <= w_p_down_nxt;
            r_sar_done <= w_sar_done_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_loss     <= w_loss_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_nxt      = r_bit;
        w_code_nxt     = r_code;
        w_lock_nxt     = r_lock;
        w_p_up_nxt     = r_p_up;
        w_p_down_nxt   = r_p_down;
        w_sar_done_nxt = 1'b0;
        w_pcnt_nxt     = r_pcnt;
        w_loss_nxt     = r_loss;
        w_trial        = r_code;

        // An active pulse holds low for PULSE_W cycles then releases
        if (w_pulse_act) begin
            if (r_pcnt != '0) begin
                w_pcnt_nxt = r_pcnt - PC_W'(1);
            end else begin
                w_p_up_nxt   = 1'b1;
                w_p_down_nxt = 1'b1;
            end
        end

        case (r_state)
            IDLE: begin
                if (io_bus.i_en) begin
                    w_state_nxt = SETTLE;
                    w_bit_nxt   = 3'd7;
                    w_code_nxt  = 8'h80;
                end
            end
            SETTLE: begin
                if (r_res_valid) w_state_nxt = MEAS;
            end
            MEAS: begin
                if (r_res_valid) begin
                    if (w_gt) w_trial[r_bit] = 1'b0;
                    if (r_bit == 3'd0) begin
                        w_state_nxt    = TRACK;
                        w_lock_nxt     = 1'b1;
                        w_sar_done_nxt = 1'b1;
                        w_loss_nxt     = '0;
                    end else begin
                        w_state_nxt       = SETTLE;
                        w_bit_nxt         = w_bit_m1;
                        w_trial[w_bit_m1] = 1'b1;
                    end
                    w_code_nxt = w_trial;
                end
            end
            TRACK: begin
                if (r_res_valid) begin
                    w_loss_nxt = w_out_tol ? w_loss_inc : '0;
                    if (w_out_tol && (w_loss_inc == LS_W'(LOSS_N))) begin
                        w_state_nxt  = SETTLE;
                        w_bit_nxt    = 3'd7;
                        w_code_nxt   = 8'h80;
                        w_lock_nxt   = 1'b0;
                        w_p_up_nxt   = 1'b1;
                        w_p_down_nxt = 1'b1;
                        w_pcnt_nxt   = '0;
                        w_loss_nxt   = '0;
                    end else if (!w_pulse_act) begin
                        if (w_lt) begin
                            w_p_up_nxt = 1'b0;
                            w_pcnt_nxt = PC_W'(PULSE_W - 1);
                        end else if (w_gt) begin
                            w_p_down_nxt = 1'b0;
                            w_pcnt_nxt   = PC_W'(PULSE_W - 1);
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (!io_bus.i_en) begin
            w_state_nxt    = IDLE;
            w_bit_nxt      = 3'd7;
            w_code_nxt     = 8'h00;
            w_lock_nxt     = 1'b0;
            w_p_up_nxt     = 1'b1;
            w_p_down_nxt   = 1'b1;
            w_sar_done_nxt = 1'b0;
            w_pcnt_nxt     = '0;
            w_loss_nxt     = '0;
        end
    end

    assign io_bus.o_code     = r_code;
    assign io_bus.o_lock     = r_lock;
    assign io_bus.o_p_up     = r_p_up;
    assign io_bus.o_p_down   = r_p_down;
    assign io_bus.o_sar_done = r_sar_done;
endmodule

// File: tb/tb_dpll_lock_ctrl.sv
// Bench for dpll_lock_ctrl: reset/enable vector table, SAR searches and tracking windows
// driven with a DCO stand-in and checked against a window-level reference model.
module tb_dpll_lock_ctrl;
    localparam int unsigned CNT_W    = 12;
    localparam int unsigned REF_WIN  = 4;
    localparam int unsigned PULSE_W  = 2;
    localparam int unsigned LOCK_TOL = 2;
    localparam int unsigned LOSS_N   = 3;
    localparam int          P        = 70;
    localparam int          WIN      = int'(REF_WIN) * P;
    localparam int          T0       = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dpll_lock_ctrl_if #(.CNT_W(CNT_W)) bus ();

    dpll_lock_ctrl #(
        .REF_WIN (REF_WIN),
        .CNT_W   (CNT_W),
        .PULSE_W (PULSE_W),
        .LOCK_TOL(LOCK_TOL),
        .LOSS_N  (LOSS_N)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int tgt, dco_off;
    bit pend_tick;
    int o_pup, o_pdn, o_both, o_sar, o_sar_nolock, o_code_sar;
    int o_code_mid, o_code_end, o_lock_min, o_lock_end;
    int m_code, m_exp, m_loss;

    typedef struct {
        bit          rst;
        bit          en;
        logic [11:0] exp;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int outs();
        return {20'd0, bus.o_code, bus.o_lock, bus.o_p_up, bus.o_p_down, bus.o_sar_done};
    endfunction

    // DCO stand-in: edges per window equal the code plus a fixed offset
    function automatic int dco_count(input int code);
        int c;
        c = code + dco_off;
        return (c < 0) ? 0 : c;
    endfunction

    // Reference SAR: code visible during search window w (two windows per bit), final at w=16
    function automatic int model_code(input int w);
        int acc;
        int trial;
        acc = 0;
        for (int b = 7; b >= 0; b--) begin
            trial = acc | (1 << b);
            if (w / 2 == 7 - b) return trial;
            if (dco_count(trial) <= tgt) acc = trial;
        end
        return acc;
    endfunction

    // One reference window: edges at 0,P,2P,3P; the closing edge is the next call's cycle 0
    task automatic run_window(input int cnt, input bit dco, input bit ct,
                              input int abort_at, input int abort_kind);
        int n;
        int body;
        o_pup = 0; o_pdn = 0; o_both = 0; o_sar = 0; o_sar_nolock = 0; o_code_sar = -1;
        o_lock_min = 1;
        n    = cnt;
        body = cnt - int'(ct);
        for (int c = 0; c < WIN; c++) begin
            bus.i_ref_edge = (c % P == 0);
            bus.i_dco_tick = (c == 0 && pend_tick) || (c >= T0 && c < T0 + body);
            if (c == abort_at) begin
                if (abort_kind == 1) bus.i_en = 1'b0;
                else rst = 1'b0;
            end
            step();
            if (!bus.o_p_up) o_pup++;
            if (!bus.o_p_down) o_pdn++;
            if (!bus.o_p_up && !bus.o_p_down) o_both++;
            if (bus.o_sar_done) begin
                o_sar++;
                o_code_sar = int'(bus.o_code);
                if (!bus.o_lock) o_sar_nolock++;
            end
            if (!bus.o_lock) o_lock_min = 0;
            if (c == 6) begin
                o_code_mid = int'(bus.o_code);
                if (dco) begin
                    n = dco_count(o_code_mid);
                    if (n > WIN - T0 - 2) n = WIN - T0 - 2;
                    body = n - int'(ct);
                end
            end
            if (c == abort_at) begin
                bus.i_ref_edge = 1'b0;
                bus.i_dco_tick = 1'b0;
                pend_tick = 1'b0;
                return;
            end
        end
        pend_tick  = ct;
        o_code_end = int'(bus.o_code);
        o_lock_end = int'(bus.o_lock);
    endtask

    task automatic do_search();
        int sar_early;
        int lock_hi;
        int fin;
        int d;
        sar_early = 0;
        lock_hi   = 0;
        for (int w = 0; w < 16; w++) begin
            run_window(0, 1'b1, 1'b0, -1, 0);
            chk($sformatf("search_code_w%0d", w), o_code_mid, model_code(w));
            sar_early += o_sar;
            lock_hi   += o_lock_end;
            if (w == 0) chk("search_start_no_pulse", o_pup + o_pdn, 0);
        end
        chk("sar_done_early", sar_early, 0);
        chk("lock_during_search", lock_hi, 0);
        fin = model_code(16);
        run_window(0, 1'b1, 1'b0, -1, 0);
        chk("sar_done_count", o_sar, 1);
        chk("lock_with_sar_done", o_sar_nolock, 0);
        chk("code_at_sar_done", o_code_sar, fin);
        chk("lock_after_search", o_lock_end, 1);
        m_code = fin;
        d      = dco_count(fin) - tgt;
        m_exp  = (d < 0) ? -1 : (d > 0) ? 1 : 0;
        m_loss = (d > int'(LOCK_TOL) || d < -int'(LOCK_TOL)) ? 1 : 0;
    endtask

    // Tracking window: observed pulses reflect the previous window's result
    task automatic track_win(input int cnt, input bit ct, output bit lost);
        int d;
        run_window(cnt, 1'b0, ct, -1, 0);
        chk("trk_p_up_cycles", o_pup, (m_exp < 0) ? int'(PULSE_W) : 0);
        chk("trk_p_down_cycles", o_pdn, (m_exp > 0) ? int'(PULSE_W) : 0);
        chk("trk_both_low", o_both, 0);
        chk("trk_lock", o_lock_min, 1);
        chk("trk_code", o_code_end, m_code);
        d = cnt - tgt;
        if (d > int'(LOCK_TOL) || d < -int'(LOCK_TOL)) m_loss++;
        else m_loss = 0;
        lost = (m_loss == int'(LOSS_N));
        if (lost) begin
            m_loss = 0;
            m_exp  = 0;
        end else begin
            m_exp = (d < 0) ? -1 : (d > 0) ? 1 : 0;
        end
    endtask

    initial begin
        bit lost;
        int cnt;
        bit ct;
        int hand_cnt[14];
        bit hand_ct[14];

        tv[0] = '{1'b0, 1'b0, 12'h006};
        tv[1] = '{1'b1, 1'b0, 12'h006};
        tv[2] = '{1'b1, 1'b1, 12'h806};
        tv[3] = '{1'b1, 1'b1, 12'h806};
        tv[4] = '{1'b1, 1'b0, 12'h006};
        tv[5] = '{1'b1, 1'b1, 12'h806};
        tv[6] = '{1'b0, 1'b1, 12'h006};
        tv[7] = '{1'b1, 1'b1, 12'h806};

        hand_cnt = '{99, 100, 110, 100, 110, 100, 110, 100, 100, 101, 100, 110, 110, 110};
        hand_ct  = '{0,  0,   0,   0,   0,   0,   0,   0,   1,   1,   0,   0,   0,   0};

        rst = 1'b0;
        bus.i_en = 1'b0;
        bus.i_ref_edge = 1'b0;
        bus.i_dco_tick = 1'b0;
        tgt = 100;
        dco_off = 0;
        pend_tick = 1'b0;
        bus.i_tgt_cnt = CNT_W'(tgt);

        for (int i = 0; i < 8; i++) begin
            rst = tv[i].rst;
            bus.i_en = tv[i].en;
            step();
            chk($sformatf("vec%0d_outputs", i), outs(), int'(tv[i].exp));
        end

        // Nominal lock at 0x64, then drift, alternating error, coincident ticks and loss
        do_search();
        lost = 1'b0;
        for (int i = 0; i < 14; i++) begin
            track_win(hand_cnt[i], hand_ct[i], lost);
        end
        chk("hand_loss_detected", int'(lost), 1);
        do_search();

        // Enable dropped mid-search
        for (int w = 0; w < 5; w++) run_window(0, 1'b1, 1'b0, -1, 0);
        run_window(0, 1'b1, 1'b0, 100, 1);
        chk("en_drop_outputs", outs(), 12'h006);
        bus.i_en = 1'b1;
        step();
        step();
        do_search();

        // Reset asserted while a p_up pulse is active
        track_win(99, 1'b0, lost);
        run_window(100, 1'b0, 1'b0, 2, 2);
        chk("rst_pulse_was_active", o_pup, 1);
        chk("rst_mid_pulse_outputs", outs(), 12'h006);
        rst = 1'b1;
        step();
        step();
        do_search();

        // Randomized targets, DCO offsets and tracking errors
        for (int r = 0; r < 2; r++) begin
            bus.i_en = 1'b0;
            step();
            tgt = int'($urandom_range(200, 30));
            dco_off = int'($urandom_range(12, 0)) - 6;
            bus.i_tgt_cnt = CNT_W'(tgt);
            bus.i_en = 1'b1;
            pend_tick = 1'b0;
            step();
            step();
            do_search();
            for (int k = 0; k < 8; k++) begin
                cnt = tgt + int'($urandom_range(8, 0)) - 4;
                ct  = 1'($urandom_range(1, 0));
                track_win(cnt, ct, lost);
                if (lost) do_search();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
